// File: rtl/text_ram_arbiter_if.sv
// Bundle of the display, writer, clear and RAM signals around the text RAM arbiter.
// The arbiter takes the slave side; the environment drives the master side.
interface text_ram_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [7:0]        disp_data;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready;

    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, mem_rdata,
        output disp_valid, disp_data, wr_ready, clr_busy, clr_done,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, mem_rdata,
        input  disp_valid, disp_data, wr_ready, clr_busy, clr_done,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/text_ram_arbiter.sv
// Shares one single-port text RAM between the display fetcher, a full-screen clear
// engine and a character writer, in that priority order.
module text_ram_arbiter #(
    parameter int         ADDR_W = 11,
    parameter int         DEPTH  = 1200,
    parameter logic [7:0] FILL   = 8'h20
) (
    input logic            clk,
    input logic            rst,
    text_ram_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] counter;
    logic              rd_pipe;
    logic              valid_q;
    logic [7:0]        data_q;
    logic              done_q;

    logic              clr_write;
    logic              clr_last;
    logic              ready;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;

    // Display reads are never stalled; the clear only yields to them, and the
    // writer is refused whenever anything else might want the RAM this cycle.
    always_comb begin
        en         = 1'b0;
        we         = 1'b0;
        addr       = bus.disp_addr;
        wdata      = FILL;
        ready      = 1'b0;
        clr_write  = 1'b0;
        state_next = state;
        if (!rst) begin
            if (bus.disp_req) begin
                en = 1'b1;
            end else if (state == CLEAR) begin
                en        = 1'b1;
                we        = 1'b1;
                addr      = counter;
                clr_write = 1'b1;
            end else if (!bus.clr_start) begin
                ready = 1'b1;
                if (bus.wr_valid && (bus.wr_addr <= LAST_ADDR)) begin
                    en    = 1'b1;
                    we    = 1'b1;
                    addr  = bus.wr_addr;
                    wdata = bus.wr_data;
                end
            end
            if ((state == IDLE) && bus.clr_start) begin
                state_next = CLEAR;
            end else if (clr_write && (counter == LAST_ADDR)) begin
                state_next = IDLE;
            end
        end
    end

    assign clr_last = clr_write && (counter == LAST_ADDR);

    // Read data lands one cycle after the command and is registered once more,
    // so a fetch surfaces on disp_valid two cycles after its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            rd_pipe <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            rd_pipe <= bus.disp_req;
            valid_q <= rd_pipe;
            done_q  <= clr_last;
            if (rd_pipe) begin
                data_q <= bus.mem_rdata;
            end
            if (state == IDLE) begin
                counter <= '0;
            end else if (clr_write) begin
                counter <= counter + ADDR_W'(1);
            end
        end
    end

    assign bus.mem_en     = en;
    assign bus.mem_we     = we;
    assign bus.mem_addr   = addr;
    assign bus.mem_wdata  = wdata;
    assign bus.wr_ready   = ready;
    assign bus.disp_valid = valid_q && !rst;
    assign bus.disp_data  = rst ? 8'h00 : data_q;
    assign bus.clr_busy   = (state == CLEAR) && !rst;
    assign bus.clr_done   = done_q && !rst;
endmodule

// File: doc/text_ram_arbiter.md
TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, text RAM address width.
REQ-002 SHALL have parameter DEPTH, default 1200, number of valid character cells (40x30).
REQ-003 SHALL have parameter FILL, default 8'h20, character code written by a clear.
REQ-004 SHALL have port clk  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port disp_req  input  1  display fetch request, one cycle per character.
REQ-007 SHALL have port disp_addr  input  ADDR_W  display fetch address.
REQ-008 SHALL have port disp_valid  output  1  fetched character valid.
REQ-009 SHALL have port disp_data  output  8  fetched character code.
REQ-010 SHALL have port wr_valid  input  1  writer request.
REQ-011 SHALL have port wr_addr  input  ADDR_W  writer address.
REQ-012 SHALL have port wr_data  input  8  writer character.
REQ-013 SHALL have port wr_ready  output  1  writer request accepted this cycle.
REQ-014 SHALL have port clr_start  input  1  start full-screen clear.
REQ-015 SHALL have port clr_busy  output  1  clear in progress.
REQ-016 SHALL have port clr_done  output  1  one-cycle pulse, clear finished.
REQ-017 SHALL have ports mem_en  output  1, mem_we  output  1, mem_addr  output  ADDR_W, mem_wdata  output  8: single-port RAM command.
REQ-018 SHALL have port mem_rdata  input  8  RAM read data, valid one cycle after a read command.

Function
REQ-019 SHALL issue at most one RAM access per cycle; priority: display read > clear write > writer write.
REQ-020 SHALL, on disp_req=1, drive mem_en=1, mem_we=0, mem_addr=disp_addr in the same cycle, in every state.
REQ-021 SHALL register mem_rdata into disp_data and assert disp_valid exactly 2 cycles after disp_req; disp_valid is high for one cycle per request; back-to-back requests give back-to-back valids.
REQ-022 SHALL hold disp_data between valids.
REQ-023 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-024 SHALL drive wr_ready=1 only when state=IDLE, disp_req=0, clr_start=0 and rst=0 (combinational).
REQ-025 SHALL, on wr_valid&wr_ready, write wr_data to wr_addr the same cycle (mem_en=1, mem_we=1); writer holds request until ready.
REQ-026 SHALL accept but suppress (mem_en=0) writer writes with wr_addr >= DEPTH.
REQ-027 SHALL, on clr_start in IDLE, enter CLEAR with clear counter=0 next cycle; clr_start in CLEAR ignored.
REQ-028 SHALL, in CLEAR on each cycle without disp_req, write FILL to counter address and increment the counter; on disp_req cycles the counter holds.
REQ-029 SHALL, when the write at address DEPTH-1 occurs, return to IDLE next cycle and pulse clr_done for exactly that cycle.
REQ-030 SHALL drive clr_busy=1 exactly while state=CLEAR.
REQ-031 SHALL drive mem_en=0, mem_we=0 when no access is granted; mem_addr/mem_wdata don't-care then.

Reset
REQ-032 SHALL, while rst=1: state=IDLE, counter=0, disp_valid=0, disp_data=0, clr_busy=0, clr_done=0, wr_ready=0, mem_en=0, pending read pipeline cleared.
REQ-033 SHALL, on rst during CLEAR, abort without clr_done; RAM contents partially cleared; reads issued the cycle before rst produce no disp_valid.

Verification
REQ-034 SHALL cover: disp_req at addr 5 with RAM[5]=0x41 -> disp_valid=1, disp_data=0x41 two cycles later, one cycle wide.
REQ-035 SHALL cover: wr_valid addr 7 data 0x42 with disp_req high 3 cycles -> wr_ready low 3 cycles, write on 4th, later read of 7 returns 0x42.
REQ-036 SHALL cover: clr_start with no display traffic -> clr_busy 1200 cycles, addresses 0..1199 written with 0x20, clr_done pulse once, wr_ready low throughout.
REQ-037 SHALL cover: clear with disp_req every 2nd cycle -> clear takes 2400 cycles, all display reads return correct data, no address skipped.
REQ-038 SHALL cover: wr_valid addr 1500 -> wr_ready=1, mem_en=0, RAM unchanged.
REQ-039 SHALL cover: rst at counter=600 -> clr_busy=0 next cycle, no clr_done, addresses 600..1199 unchanged.
